debounce_ctrl: RTL and testbench

Debounce controller for one raw mechanical input (button or switch). A four-state FSM sequences a settle-timer counter (clear/increment/roll-over), so a new level is accepted only after it has held for a full settle interval. Outputs are a clean level plus one-cycle rise and fall pulses. It sits between board I/O and the user logic, one instance per button.

---
 rtl/debounce_pkg.sv | 26 ++
 rtl/settle_timer.sv | 36 +++
 rtl/debounce_ctrl.sv | 126 ++++++++++++
 tb/tb_debounce_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce controller.
// The DEBOUNCE_SYNC_EN macro (see debounce_ctrl) selects the optional synchronizer.
package debounce_pkg;

    // Four-state debounce sequencer: two stable levels, two candidate waits
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // Depth of the optional input synchronizer chain
    localparam int unsigned SYNC_DEPTH = 2;

    // True while a candidate level change is being timed
    function automatic logic is_waiting(input state_t st);
        return (st == WAIT_HI) || (st == WAIT_LO);
    endfunction

    // Level that a given state is currently trying to reach or holding
    function automatic logic target_level(input state_t st);
        return (st == WAIT_HI) || (st == STABLE_HI);
    endfunction

endpackage : debounce_pkg

// File: rtl/settle_timer.sv
// Settle-interval counter: clear, increment and a terminal flag at SETTLE_CYCLES-1.
// Clear has priority over increment; the count never advances past the terminal value.
module settle_timer
    import debounce_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 500000,
    parameter int unsigned WIDTH         = $clog2(SETTLE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic increment,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(SETTLE_CYCLES - 1);

    logic [WIDTH-1:0] count;

    // Counter register: clear wins, increment only below the terminal value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (increment && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // Terminal flag marks the last tick of the settle interval
    always_comb begin
        terminal = (count == LAST);
    end

endmodule : settle_timer

// File: rtl/debounce_ctrl.sv
// Debounce controller for one raw input: FSM + settle timer, registered level and pulses.
// Optional feature: define DEBOUNCE_SYNC_EN to insert a two-flop synchronizer on noisy.
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 500000,
    parameter int unsigned WIDTH         = $clog2(SETTLE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy,
    input  logic tick,
    output logic debounced,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic settling
);

    state_t state;
    logic   s;
    logic   timer_clear;
    logic   timer_inc;
    logic   terminal;

`ifdef DEBOUNCE_SYNC_EN
    logic [SYNC_DEPTH-1:0] sync_q;

    // Two-flop synchronizer; the FSM samples the last stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], noisy};
        end
    end

    assign s = sync_q[SYNC_DEPTH-1];
`else
    assign s = noisy;
`endif

    // Timer control: cleared outside WAIT, on abort and on acceptance; advanced on tick
    always_comb begin
        timer_clear = 1'b0;
        timer_inc   = 1'b0;
        if (!is_waiting(state)) begin
            timer_clear = 1'b1;
        end else if (s != target_level(state)) begin
            timer_clear = 1'b1;
        end else if (tick) begin
            if (terminal) begin
                timer_clear = 1'b1;
            end else begin
                timer_inc = 1'b1;
            end
        end
    end

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .WIDTH        (WIDTH)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .increment(timer_inc),
        .terminal (terminal)
    );

    // Sequencer with registered level, pulse and settling outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= STABLE_LO;
            debounced  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            settling   <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s) begin
                        state    <= WAIT_HI;
                        settling <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    // bounce-back checked first so it also wins on the terminal tick
                    if (!s) begin
                        state    <= STABLE_LO;
                        settling <= 1'b0;
                    end else if (tick && terminal) begin
                        state      <= STABLE_HI;
                        settling   <= 1'b0;
                        debounced  <= 1'b1;
                        rise_pulse <= 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state    <= WAIT_LO;
                        settling <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state    <= STABLE_HI;
                        settling <= 1'b0;
                    end else if (tick && terminal) begin
                        state      <= STABLE_LO;
                        settling   <= 1'b0;
                        debounced  <= 1'b0;
                        fall_pulse <= 1'b1;
                    end
                end
                default: begin
                    state     <= STABLE_LO;
                    settling  <= 1'b0;
                    debounced <= 1'b0;
                end
            endcase
        end
    end

endmodule : debounce_ctrl

// File: tb/tb_debounce_ctrl.sv
// Self-checking bench for debounce_ctrl (SETTLE_CYCLES=4, synchronizer disabled).
module tb_debounce_ctrl;

    localparam int S = 4;

    logic clk;
    logic reset;
    logic noisy;
    logic tick;
    logic debounced;
    logic rise_pulse;
    logic fall_pulse;
    logic settling;

    int checks = 0;
    int passes = 0;
    bit check_en = 0;

    debounce_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .noisy     (noisy),
        .tick      (tick),
        .debounced (debounced),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .settling  (settling)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: accepted level plus a candidate that counts ticked edges since entry
    logic m_level   = 1'b0;
    bit   m_cand    = 0;
    int   m_ticks   = 0;
    logic m_rise    = 1'b0;
    logic m_fall    = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_level = 1'b0;
            m_cand  = 0;
            m_ticks = 0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (noisy == m_level) begin
                m_cand = 0;
            end else if (!m_cand) begin
                m_cand  = 1;
                m_ticks = 0;
            end else if (tick) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == S) begin
                    m_level = noisy;
                    m_cand  = 0;
                    if (noisy) m_rise = 1'b1;
                    else       m_fall = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b (debounced,rise,fall,settling) at %0t",
                      name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en)
            check("model", {debounced, rise_pulse, fall_pulse, settling},
                  {m_level, m_rise, m_fall, logic'(m_cand)});
    end

    task automatic run(input logic n, input logic t, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            noisy = n;
            tick  = t;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] outs();
        return {debounced, rise_pulse, fall_pulse, settling};
    endfunction

    int mode;
    int found;

    initial begin
        reset = 1'b1;
        noisy = 1'b0;
        tick  = 1'b1;
        #1;
        check("reset_state", outs(), 4'b0000);
        check_en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run(0, 1, 5);

        // clean press
        run(1, 1, 1);
        check("press_entry", outs(), 4'b0001);
        run(1, 1, 3);
        check("press_early", outs(), 4'b0001);
        run(1, 1, 1);
        check("press_accept", outs(), 4'b1100);
        run(1, 1, 1);
        check("press_single", outs(), 4'b1000);

        // release
        run(0, 1, 1);
        check("release_entry", outs(), 4'b1001);
        run(0, 1, 3);
        run(0, 1, 1);
        check("release_accept", outs(), 4'b0010);
        run(0, 1, 1);
        check("release_single", outs(), 4'b0000);

        // bounce during WAIT_HI
        run(1, 1, 3);
        run(0, 1, 1);
        check("bounce_abort", outs(), 4'b0000);
        run(1, 1, 4);
        check("bounce_no_early", outs(), 4'b0001);
        run(1, 1, 1);
        check("bounce_accept", outs(), 4'b1100);

        // bounce-back on the terminal tick aborts the release
        run(0, 1, 4);
        run(1, 1, 1);
        check("terminal_abort", outs(), 4'b1000);
        run(0, 1, 6);
        check("back_low", outs(), 4'b0000);

        // async reset mid-WAIT_HI
        run(1, 1, 2);
        #2 reset = 1'b1;
        #1;
        check("reset_async", outs(), 4'b0000);
        noisy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run(0, 1, 8);
        check("reset_no_pulse", outs(), 4'b0000);

        // tick every 3rd cycle: entry at edge 0, ticks at 2,5,8,11 -> accept after 12 edges
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            run(1, logic'(c % 3 == 2), 1);
            if (debounced) found = c + 1;
        end
        checks++;
        if (found == 12) passes++;
        else $display("FAIL tick_gating: accepted after %0d edges, expected 12", found);
        run(0, 1, 6);

        // noisy already high at reset release
        noisy = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run(1, 1, 1);
        check("release_high_entry", outs(), 4'b0001);
        run(1, 1, 4);
        check("release_high_accept", outs(), 4'b1100);

        // randomized phase, checked each cycle against the model
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) mode = $urandom_range(0, 2);
            if ($urandom_range(0, (mode == 1) ? 24 : 8) == 0) noisy = ~noisy;
            case (mode)
                0:       tick = 1'b1;
                1:       tick = logic'(c % 3 == 0);
                default: tick = logic'($urandom_range(0, 1));
            endcase
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        check_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_debounce_ctrl
